ps2_port_ctrl: RTL and testbench
================================

Name: ps2_port_ctrl

Overview:
Parametrised bidirectional PS/2 host port. It succeeds the receive-only mouse interface. It receives device frames into a byte FIFO, checks start, stop and parity, detects stalled frames, and transmits host commands such as 0xF4 (enable streaming) with ACK check. It sits on the CPU I/O bus behind io_cs/addr and drives MOUSE_CLOCK/MOUSE_DATA as open-drain lines.

Parameters:
DATA_W, 16, I/O read bus width; minimum 16.
FIFO_DEPTH, 8, RX byte FIFO depth; power of 2, 2..64.
FILTER_LEN, 4, consecutive equal samples needed to accept a PS/2 clock level change.
INHIBIT_CYCLES, 5000, clk cycles MOUSE_CLOCK is held low before a TX (100 us at 50 MHz).
TIMEOUT_CYCLES, 100000, maximum clk cycles between device clock falls inside a frame.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low.
io_cs  in  1  I/O chip select; one-cycle access strobe.
wr  in  1  1 = write, 0 = read; qualified by io_cs.
addr  in  2  register select.
wdata  in  8  write data.
rdata  out  DATA_W  read data; registered.
RDA  out  1  RX FIFO non-empty.
t_clk  out  1  1 while host drives MOUSE_CLOCK low.
MOUSE_CLOCK  inout  1  PS/2 clock; pulled low or z only.
MOUSE_DATA  inout  1  PS/2 data; pulled low or z only.

Behaviour:
- Reset (rst=0 at a clk edge):
  - rdata=0, RDA=0, t_clk=0, both lines z.
  - FIFO empty, sticky flags clear, rx_en=1, FSMs IDLE.
  - Reset mid-TX releases both lines on that edge.
- Input conditioning: 2-FF synchronisers on both lines. Clock glitch filter of FILTER_LEN samples. A fall event is a filtered 1->0 transition.
- RX FSM, states IDLE and RX_BITS:
  - IDLE -> RX_BITS on a fall while rx_en=1 and TX is IDLE.
  - Sample MOUSE_DATA on each fall: 11 bits = start(0), D0..D7 LSB first, odd parity, stop(1).
  - After bit 11, return to IDLE.
  - Good frame: push byte.
  - Start or stop error: set FERR. Parity error: set PERR. Bad frames are not pushed.
  - No fall for TIMEOUT_CYCLES in RX_BITS: abort to IDLE, set TOUT, discard partial byte.
- FIFO:
  - Push while full with no simultaneous pop: byte dropped, OVF set.
  - Simultaneous push and pop: both happen, count unchanged; push is allowed when full.
  - RDA = (count != 0), registered state.
- TX FSM, states IDLE, INHIBIT, REQ, TX_BITS, ACK, DONE:
  - Write addr 2 while IDLE: latch wdata, clear ACKOK, go to INHIBIT. Write while not IDLE: ignored.
  - INHIBIT: drive clock low (t_clk=1) for exactly INHIBIT_CYCLES.
  - REQ: drive data low, release clock; next fall -> TX_BITS.
  - TX_BITS: on each fall present the next bit: D0..D7, then odd parity, then release data (stop).
  - ACK: sample data on the following fall. 0 sets ACKOK=1; 1 leaves it at 0.
  - ACK then -> DONE -> IDLE.
  - TIMEOUT_CYCLES with no fall in REQ, TX_BITS or ACK: release lines, set TOUT, go to IDLE.
- Register map (io_cs=1; rdata valid the cycle after the strobe, held until the next read; unused bits 0):
  - Read 0: [7:0] FIFO head, [8] valid; pops if non-empty. Empty read returns 0.
  - Read 1, status: [0] RDA, [1] full, [2] tx_busy, [3] ACKOK, [4] PERR, [5] FERR, [6] TOUT, [7] OVF, [15:8] count. This read clears [7:4]; a flag set in the same cycle stays set.
  - Write 2: TX command byte.
  - Write 3: control. [0] rx_en. [1] flush: empties the FIFO, self-clearing; a same-cycle push is lost.
  - Reads of 2 or 3 return 0. Writes to 0 or 1 are ignored.

Decomposition:
- Package ps2_pkg holds:
  - rx_state_t and tx_state_t enums;
  - REG_DATA/REG_STAT/REG_TX/REG_CTRL address constants;
  - status bit indices;
  - PS2_CMD_ENABLE=8'hF4, PS2_ACK=8'hFA;
  - frame length 11.
- One sub-module: ps2_fifo, a synchronous FIFO parametrised on depth with push, pop, flush, count, full and empty.

Test Plan:
1. Device model sends 0xFA, parity 1. -> RDA=1; read addr 0 -> rdata=16'h01FA, RDA=0.
2. Device sends 0x55 with parity 0 (bad). -> No push, RDA=0. Status read: [4]=1. Second status read: [4]=0.
3. FIFO_DEPTH=8; send 0x01..0x09 with no reads. -> count=8, [1]=1, [7]=1. Eight reads return 0x101..0x108; ninth read returns 0.
4. Write 0xF4 to addr 2.
   - t_clk high exactly 5000 cycles, then data low.
   - Device sees bits 0,0,1,0,1,1,1,1 and parity 0.
   - Device ACKs: ACKOK=1, tx_busy=0.
   - Repeat with no ACK: ACKOK=0.
5. Device gives 5 falls then stops. -> After TIMEOUT_CYCLES: TOUT=1, RX IDLE. Next 0xAA frame is received as 0x1AA.
6. Assert rst=0 for one cycle mid-INHIBIT. -> Next edge: t_clk=0, lines z, status=0, a following TX completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host port
package ps2_pkg;

   typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK, TX_DONE} tx_state_t;

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_STAT = 2'd1;
   localparam logic [1:0] REG_TX   = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int ST_RDA   = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_ACKOK = 3;
   localparam int ST_PERR  = 4;
   localparam int ST_FERR  = 5;
   localparam int ST_TOUT  = 6;
   localparam int ST_OVF   = 7;

   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
   localparam logic [7:0] PS2_ACK        = 8'hFA;
   localparam int         FRAME_LEN      = 11;

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - synchronous byte FIFO; a push into a full FIFO succeeds only alongside a pop
module ps2_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [7:0]             wdata_i,
   output logic [7:0]             rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/ps2_port_ctrl.sv
// rtl/ps2_port_ctrl.sv - bidirectional PS/2 host port: filtered RX into a FIFO, host TX with ACK check
module ps2_port_ctrl
   import ps2_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 4,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              io_cs,
   input  logic              wr,
   input  logic [1:0]        addr,
   input  logic [7:0]        wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              RDA,
   output logic              t_clk,
   inout  wire               MOUSE_CLOCK,
   inout  wire               MOUSE_DATA
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]        clk_sync_q, dat_sync_q;
   logic [FW-1:0]     filt_cnt_q;
   logic              clk_filt_q, filt_accept, fall, dat_s;

   rx_state_t         rx_state_q, rx_state_d;
   logic [3:0]        rx_cnt_q, rx_cnt_d;
   logic [9:0]        rx_shift_q, rx_shift_d;
   logic [10:0]       rx_frame;
   tx_state_t         tx_state_q, tx_state_d;
   logic [3:0]        tx_cnt_q, tx_cnt_d;
   logic [9:0]        tx_shift_q, tx_shift_d;
   logic              tx_data_low_q, tx_data_low_d;
   logic [IW-1:0]     inh_cnt_q, inh_cnt_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic              ackok_q, ackok_d, perr_q, perr_d, ferr_q, ferr_d;
   logic              tout_q, tout_d, ovf_q, ovf_d, rx_en_q, rx_en_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [15:0]       stat;

   logic              stat_rd, fifo_pop, flush, tx_wr;
   logic              rx_push, set_ferr, set_perr, set_ack, clr_ack, to_active, to_expire;
   logic [7:0]        fifo_rdata;
   logic [AW:0]       fifo_count;
   logic              fifo_full, fifo_empty;

   assign MOUSE_CLOCK = (tx_state_q == TX_INHIBIT) ? 1'b0 : 1'bz;
   assign MOUSE_DATA  = tx_data_low_q ? 1'b0 : 1'bz;
   assign t_clk       = (tx_state_q == TX_INHIBIT);
   assign rdata       = rdata_q;
   assign RDA         = !fifo_empty;

   assign stat_rd  = io_cs && !wr && (addr == REG_STAT);
   assign fifo_pop = io_cs && !wr && (addr == REG_DATA);
   assign flush    = io_cs && wr && (addr == REG_CTRL) && wdata[1];
   assign tx_wr    = io_cs && wr && (addr == REG_TX);

   // A clock level change is accepted only after FILTER_LEN consecutive differing samples.
   assign filt_accept = (clk_sync_q[1] != clk_filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
   assign fall        = filt_accept && clk_filt_q;
   assign dat_s       = dat_sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_cnt_q <= '0;
         clk_filt_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[0], MOUSE_CLOCK};
         dat_sync_q <= {dat_sync_q[0], MOUSE_DATA};
         if (clk_sync_q[1] == clk_filt_q) filt_cnt_q <= '0;
         else if (filt_accept) begin
            clk_filt_q <= clk_sync_q[1];
            filt_cnt_q <= '0;
         end else filt_cnt_q <= filt_cnt_q + FW'(1);
      end
   end

   ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rx_push),
      .pop_i   (fifo_pop),
      .flush_i (flush),
      .wdata_i (rx_frame[8:1]),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_state_d    = tx_state_q;
      tx_cnt_d      = tx_cnt_q;
      tx_shift_d    = tx_shift_q;
      tx_data_low_d = tx_data_low_q;
      inh_cnt_d     = inh_cnt_q;
      to_cnt_d      = '0;
      rx_push       = 1'b0;
      set_ferr      = 1'b0;
      set_perr      = 1'b0;
      set_ack       = 1'b0;
      clr_ack       = 1'b0;
      rx_frame      = {dat_s, rx_shift_q};
      to_active     = (rx_state_q == RX_BITS) || (tx_state_q inside {TX_REQ, TX_BITS, TX_ACK});
      to_expire     = to_active && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
      if (to_active && !fall) to_cnt_d = to_cnt_q + TW'(1);

      // A host transmission overrides any device frame in progress.
      case (rx_state_q)
         RX_IDLE: if (fall && rx_en_q && tx_state_q == TX_IDLE) begin
            rx_state_d = RX_BITS;
            rx_cnt_d   = 4'd1;
            rx_shift_d = {dat_s, rx_shift_q[9:1]};
         end
         RX_BITS: if (tx_state_q != TX_IDLE || to_expire) rx_state_d = RX_IDLE;
         else if (fall) begin
            rx_shift_d = {dat_s, rx_shift_q[9:1]};
            rx_cnt_d   = rx_cnt_q + 4'd1;
            if (rx_cnt_q == 4'(FRAME_LEN - 1)) begin
               rx_state_d = RX_IDLE;
               set_ferr   = rx_frame[0] || !rx_frame[10];
               set_perr   = !(^rx_frame[9:1]);
               rx_push    = !set_ferr && !set_perr;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase

      case (tx_state_q)
         TX_IDLE: if (tx_wr) begin
            tx_state_d = TX_INHIBIT;
            tx_shift_d = {1'b1, ~^wdata, wdata};
            inh_cnt_d  = '0;
            clr_ack    = 1'b1;
         end
         TX_INHIBIT: if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
            tx_state_d    = TX_REQ;
            tx_data_low_d = 1'b1;
         end else inh_cnt_d = inh_cnt_q + IW'(1);
         TX_REQ, TX_BITS: if (to_expire) begin
            tx_state_d    = TX_IDLE;
            tx_data_low_d = 1'b0;
         end else if (fall) begin
            // Shift queue is {stop, parity, D7..D0}; the stop bit releases the line.
            tx_data_low_d = !tx_shift_q[0];
            tx_shift_d    = {1'b1, tx_shift_q[9:1]};
            tx_cnt_d      = (tx_state_q == TX_REQ) ? 4'd0 : tx_cnt_q + 4'd1;
            if (tx_state_q == TX_REQ) tx_state_d = TX_BITS;
            else if (tx_cnt_q == 4'd8) tx_state_d = TX_ACK;
         end
         TX_ACK: if (to_expire) begin
            tx_state_d    = TX_IDLE;
            tx_data_low_d = 1'b0;
         end else if (fall) begin
            set_ack    = !dat_s;
            tx_state_d = TX_DONE;
         end
         default: begin
            tx_state_d    = TX_IDLE;
            tx_data_low_d = 1'b0;
         end
      endcase

      ackok_d = set_ack ? 1'b1 : (clr_ack ? 1'b0 : ackok_q);
      perr_d  = (perr_q && !stat_rd) || set_perr;
      ferr_d  = (ferr_q && !stat_rd) || set_ferr;
      tout_d  = (tout_q && !stat_rd) || to_expire;
      ovf_d   = (ovf_q  && !stat_rd) || (rx_push && fifo_full && !fifo_pop && !flush);
      rx_en_d = (io_cs && wr && addr == REG_CTRL) ? wdata[0] : rx_en_q;

      stat           = '0;
      stat[ST_RDA]   = !fifo_empty;
      stat[ST_FULL]  = fifo_full;
      stat[ST_BUSY]  = (tx_state_q != TX_IDLE);
      stat[ST_ACKOK] = ackok_q;
      stat[ST_PERR]  = perr_q;
      stat[ST_FERR]  = ferr_q;
      stat[ST_TOUT]  = tout_q;
      stat[ST_OVF]   = ovf_q;
      stat[15:8]     = 8'(fifo_count);

      rdata_d = rdata_q;
      if (io_cs && !wr) begin
         rdata_d = '0;
         case (addr)
            REG_DATA: if (!fifo_empty) rdata_d[8:0] = {1'b1, fifo_rdata};
            REG_STAT: rdata_d[15:0] = stat;
            default:  rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state_q    <= RX_IDLE;
         rx_cnt_q      <= '0;
         rx_shift_q    <= '0;
         tx_state_q    <= TX_IDLE;
         tx_cnt_q      <= '0;
         tx_shift_q    <= '0;
         tx_data_low_q <= 1'b0;
         inh_cnt_q     <= '0;
         to_cnt_q      <= '0;
         ackok_q       <= 1'b0;
         perr_q        <= 1'b0;
         ferr_q        <= 1'b0;
         tout_q        <= 1'b0;
         ovf_q         <= 1'b0;
         rx_en_q       <= 1'b1;
         rdata_q       <= '0;
      end else begin
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_shift_q    <= tx_shift_d;
         tx_data_low_q <= tx_data_low_d;
         inh_cnt_q     <= inh_cnt_d;
         to_cnt_q      <= to_cnt_d;
         ackok_q       <= ackok_d;
         perr_q        <= perr_d;
         ferr_q        <= ferr_d;
         tout_q        <= tout_d;
         ovf_q         <= ovf_d;
         rx_en_q       <= rx_en_d;
         rdata_q       <= rdata_d;
      end
   end

endmodule

// File: tb/tb_ps2_port_ctrl.sv
// tb/tb_ps2_port_ctrl.sv - directed bench for ps2_port_ctrl with a PS/2 device model and read scoreboard
module tb_ps2_port_ctrl;
   localparam int HALF = 15;
   localparam int TOUT = 2000;
   localparam int INH  = 5000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        io_cs = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [7:0]  wdata = 8'd0;
   logic [15:0] rdata;
   logic        RDA;
   logic        t_clk;
   tri1         ps2_clk;
   tri1         ps2_dat;
   logic        dev_clk_low = 1'b0;
   logic        dev_dat_low = 1'b0;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] d;

   assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   ps2_port_ctrl #(
      .DATA_W(16), .FIFO_DEPTH(8), .FILTER_LEN(4), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk(clk), .rst(rst), .io_cs(io_cs), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .RDA(RDA), .t_clk(t_clk), .MOUSE_CLOCK(ps2_clk), .MOUSE_DATA(ps2_dat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [15:0] q);
      io_cs = 1'b1; wr = 1'b0; addr = a;
      @(negedge clk);
      io_cs = 1'b0;
      q = rdata;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
      io_cs = 1'b1; wr = 1'b1; addr = a; wdata = v;
      @(negedge clk);
      io_cs = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_data(input string tag);
      logic [15:0] q, e;
      bus_rd(2'd0, q);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
      chk(tag, q, e);
   endtask

   // Device frame: start 0, data LSB first, parity (odd unless bad_par), stop 1.
   task automatic dev_send(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_dat_low = !f[i];
         idle(HALF);
         dev_clk_low = 1'b1;
         idle(HALF);
         dev_clk_low = 1'b0;
      end
      dev_dat_low = 1'b0;
      idle(2 * HALF);
   endtask

   task automatic host_tx(input string tag, input logic [7:0] cmd, input logic ack);
      int          cnt, g;
      logic [9:0]  got;
      logic [15:0] q;
      cnt = 0; g = 0; got = '0;
      while (t_clk !== 1'b1 && g < 10) begin g++; @(negedge clk); end
      while (t_clk === 1'b1 && cnt < INH + 1000) begin cnt++; @(negedge clk); end
      chk({tag, "_inhibit_len"}, cnt, INH);
      chk({tag, "_req_data"}, ps2_dat, 1'b0);
      chk({tag, "_req_clk"}, ps2_clk, 1'b1);
      idle(20);
      for (int i = 0; i < 10; i++) begin
         dev_clk_low = 1'b1;
         idle(HALF);
         got[i] = ps2_dat;
         dev_clk_low = 1'b0;
         idle(HALF);
      end
      chk({tag, "_bits"}, got, {1'b1, ~^cmd, cmd});
      if (ack) dev_dat_low = 1'b1;
      idle(HALF);
      dev_clk_low = 1'b1;
      idle(HALF);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      idle(HALF);
      bus_rd(2'd1, q);
      chk({tag, "_status"}, q, ack ? 16'h0008 : 16'h0000);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      idle(5);
      rst = 1'b1;
      idle(2);
      chk("reset_rdata", rdata, 16'h0000);
      chk("reset_rda", RDA, 1'b0);
      chk("reset_tclk", t_clk, 1'b0);
      chk("reset_clk_line", ps2_clk, 1'b1);
      chk("reset_dat_line", ps2_dat, 1'b1);
      idle(10);

      // good frame 0xFA
      dev_send(8'hFA, 1'b0, 11);
      exp_q.push_back(16'h01FA);
      chk("rx_fa_rda", RDA, 1'b1);
      rd_data("rx_fa_data");
      chk("rx_fa_rda_after", RDA, 1'b0);

      // bad parity frame
      dev_send(8'h55, 1'b1, 11);
      chk("perr_rda", RDA, 1'b0);
      bus_rd(2'd1, d);
      chk("perr_status1", d, 16'h0010);
      bus_rd(2'd1, d);
      chk("perr_status2", d, 16'h0000);

      // overflow: nine frames into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) begin
         dev_send(8'(i), 1'b0, 11);
         if (i <= 8) exp_q.push_back(16'h0100 | 16'(i));
      end
      bus_rd(2'd1, d);
      chk("ovf_status", d, 16'h0883);
      for (int i = 0; i < 9; i++) rd_data($sformatf("ovf_read%0d", i));
      chk("ovf_rda_after", RDA, 1'b0);

      // host command with and without ACK
      bus_wr(2'd2, 8'hF4);
      host_tx("tx_ack", 8'hF4, 1'b1);
      idle(10);
      bus_wr(2'd2, 8'hF4);
      host_tx("tx_noack", 8'hF4, 1'b0);
      idle(10);

      // stalled frame, then a clean one
      dev_send(8'h00, 1'b0, 5);
      idle(TOUT + 100);
      bus_rd(2'd1, d);
      chk("tout_status", d, 16'h0040);
      dev_send(8'hAA, 1'b0, 11);
      exp_q.push_back(16'h01AA);
      rd_data("tout_next_frame");

      // reset during inhibit
      bus_wr(2'd2, 8'hF4);
      idle(100);
      chk("midtx_tclk_before", t_clk, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midtx_tclk", t_clk, 1'b0);
      chk("midtx_clk_line", ps2_clk, 1'b1);
      chk("midtx_dat_line", ps2_dat, 1'b1);
      chk("midtx_rdata", rdata, 16'h0000);
      idle(20);
      bus_rd(2'd1, d);
      chk("midtx_status", d, 16'h0000);
      bus_wr(2'd2, 8'hF4);
      host_tx("tx_after_rst", 8'hF4, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
